register_file_param: RTL and testbench

Parametrised general-purpose register file, the successor to the fixed 8x16 two-read/one-write register array. Adds configurable width and depth, an optional hardwired zero register, and optional write-to-read bypass. Adds a per-register pending (scoreboard) bit for in-flight results. Replaces the one-shot array reset with a sequential clear engine, so the storage can map to RAM and be re-cleared at runtime. Sits in the datapath between decode (read and reserve) and writeback (write).

---
 rtl/register_file_param_if.sv | 57 +++++
 rtl/register_file_param.sv | 188 ++++++++++++++++++
 tb/tb_register_file_param.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_param_if.sv
// -----------------------------------------------------------------------------
// register_file_param_if
//
// Purpose : Bundles the control, write, reserve and read signals of
//           register_file_param into one interface. clk and rst are not part
//           of the bundle.
//
// Signals :
//   clear_req        request a full re-clear of the storage
//   busy             clear engine running (reads/pending forced to 0)
//   reg_write_*      writeback port (strobe, address, data)
//   rsv_en/rsv_addr  mark a register as having a result in flight
//   reg_read_addr_N  read port N address
//   reg_read_data_N  read port N data (combinational)
//   pend_N           pending bit of the register addressed by port N
//
// Modports: master drives requests and observes results (decode/writeback
//           side); slave is the register file itself.
// -----------------------------------------------------------------------------
interface register_file_param_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              clear_req;
   logic              busy;
   logic              reg_write_en;
   logic [ADDR_W-1:0] reg_write_dest;
   logic [DATA_W-1:0] reg_write_data;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic [ADDR_W-1:0] reg_read_addr_1;
   logic [DATA_W-1:0] reg_read_data_1;
   logic              pend_1;
   logic [ADDR_W-1:0] reg_read_addr_2;
   logic [DATA_W-1:0] reg_read_data_2;
   logic              pend_2;

   modport master (
      output clear_req,
      output reg_write_en, reg_write_dest, reg_write_data,
      output rsv_en, rsv_addr,
      output reg_read_addr_1, reg_read_addr_2,
      input  busy,
      input  reg_read_data_1, pend_1,
      input  reg_read_data_2, pend_2
   );

   modport slave (
      input  clear_req,
      input  reg_write_en, reg_write_dest, reg_write_data,
      input  rsv_en, rsv_addr,
      input  reg_read_addr_1, reg_read_addr_2,
      output busy,
      output reg_read_data_1, pend_1,
      output reg_read_data_2, pend_2
   );
endinterface : register_file_param_if

// File: rtl/register_file_param.sv
// -----------------------------------------------------------------------------
// register_file_param
//
// Purpose : Parametrised two-read / one-write register file with an optional
//           hardwired zero register, optional write-to-read bypass, a
//           per-register pending (scoreboard) bit and a sequential clear
//           engine that zeroes the storage one entry per clock after reset
//           or on request.
//
// Parameters:
//   DATA_W   register width
//   ADDR_W   address width, DEPTH = 2**ADDR_W
//   ZERO_REG 1 = register 0 reads 0, ignores writes, never pending
//   BYPASS   1 = same-cycle write data forwarded to the read ports
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset; restarts the clear from entry 0
//   bus  register_file_param_if.slave (see interface for signal list)
// -----------------------------------------------------------------------------
module register_file_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter bit ZERO_REG = 1'b0,
   parameter bit BYPASS   = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   register_file_param_if.slave bus
);

   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   state_e            state_q,   state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [DEPTH-1:0]  pend_q,    pend_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic              busy;
   logic              wv;        // qualified write (zero-register writes removed)
   logic              rv;        // qualified reserve
   logic [DATA_W-1:0] rd_data_1, rd_data_2;
   logic              rd_pend_1, rd_pend_2;
   logic              byp_1,     byp_2;

   // --------------------------------------------------------------------------
   // Request qualification. wv deliberately ignores state and clear_req: the
   // bypass path uses it as-is, while the commit below adds the READY /
   // no-clear conditions.
   // --------------------------------------------------------------------------
   assign busy  = (state_q == ST_CLEAR);
   assign wv    = bus.reg_write_en & ~(ZERO_REG && (bus.reg_write_dest == '0));
   assign rv    = bus.rsv_en       & ~(ZERO_REG && (bus.rsv_addr == '0));
   assign byp_1 = BYPASS && wv && (bus.reg_write_dest == bus.reg_read_addr_1);
   assign byp_2 = BYPASS && wv && (bus.reg_write_dest == bus.reg_read_addr_2);

   // --------------------------------------------------------------------------
   // Next-state logic: clear engine, write commit and pending scoreboard.
   // --------------------------------------------------------------------------
   always_comb begin : next_state
      // NOTE: every signal gets a default before any branch so no path leaves
      // it unassigned; otherwise synthesis would infer a latch.
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      pend_d    = pend_q;
      mem_we    = 1'b0;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;

      case (state_q)
         ST_CLEAR: begin
            // Writes, reserves and clear requests are dropped while clearing.
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == LAST_IDX) begin
               state_d = ST_READY;
            end
         end

         ST_READY: begin
            if (bus.clear_req) begin
               // Clear wins over a same-cycle write or reserve.
               state_d   = ST_CLEAR;
               clr_ptr_d = '0;
               pend_d    = '0;
            end else begin
               if (wv) begin
                  mem_we                      = 1'b1;
                  mem_waddr                   = bus.reg_write_dest;
                  mem_wdata                   = bus.reg_write_data;
                  pend_d[bus.reg_write_dest]  = 1'b0;
               end
               // Applied after the write so a same-address reserve (a newer
               // producer) leaves the register pending.
               if (rv) begin
                  pend_d[bus.rsv_addr] = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Control state registers.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples values from before the edge, independent of statement order.
      if (!rst) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
         pend_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         pend_q    <= pend_d;
      end
   end

   // --------------------------------------------------------------------------
   // Storage array.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset branch so it can map onto RAM; the clear
      // engine zeroes it one entry per clock instead.
      if (rst && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // --------------------------------------------------------------------------
   // Read ports. Assignments run lowest priority first, so the later
   // overrides give: busy, zero register, bypass, array.
   // --------------------------------------------------------------------------
   always_comb begin : read_port_1
      rd_data_1 = mem_q[bus.reg_read_addr_1];
      if (byp_1) begin
         rd_data_1 = bus.reg_write_data;
      end
      if (ZERO_REG && (bus.reg_read_addr_1 == '0)) begin
         rd_data_1 = '0;
      end
      if (busy) begin
         rd_data_1 = '0;
      end
   end

   always_comb begin : read_port_2
      rd_data_2 = mem_q[bus.reg_read_addr_2];
      if (byp_2) begin
         rd_data_2 = bus.reg_write_data;
      end
      if (ZERO_REG && (bus.reg_read_addr_2 == '0)) begin
         rd_data_2 = '0;
      end
      if (busy) begin
         rd_data_2 = '0;
      end
   end

   // A bypassed write resolves the pending result in the same cycle; a
   // same-cycle reserve only shows up from the next cycle.
   assign rd_pend_1 = pend_q[bus.reg_read_addr_1] & ~busy & ~byp_1;
   assign rd_pend_2 = pend_q[bus.reg_read_addr_2] & ~busy & ~byp_2;

   assign bus.busy            = busy;
   assign bus.reg_read_data_1 = rd_data_1;
   assign bus.reg_read_data_2 = rd_data_2;
   assign bus.pend_1          = rd_pend_1;
   assign bus.pend_2          = rd_pend_2;

endmodule : register_file_param

// File: tb/tb_register_file_param.sv
// -----------------------------------------------------------------------------
// tb_register_file_param
//
// Three instances of register_file_param:
//   dut_a : DATA_W=16, ADDR_W=3, ZERO_REG=0, BYPASS=1
//   dut_b : DATA_W=16, ADDR_W=3, ZERO_REG=1, BYPASS=0
//   dut_c : DATA_W=32, ADDR_W=5, ZERO_REG=0, BYPASS=1
// dut_a and dut_b receive identical stimulus. The stimulus process pushes the
// hand-computed expected outputs for the current cycle into a scoreboard; a
// monitor on the falling clock edge pops every queued entry and compares it
// with the live DUT output.
// -----------------------------------------------------------------------------
module tb_register_file_param;

   localparam int F_BUSY = 0;
   localparam int F_RD1  = 1;
   localparam int F_RD2  = 2;
   localparam int F_P1   = 3;
   localparam int F_P2   = 4;

   localparam int D_A = 0;
   localparam int D_B = 1;
   localparam int D_C = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // shared stimulus for dut_a / dut_b
   logic        rst_ab;
   logic        clr_req;
   logic        wr_en;
   logic [2:0]  wr_dest;
   logic [15:0] wr_data;
   logic        rsv_en;
   logic [2:0]  rsv_addr;
   logic [2:0]  ra1;
   logic [2:0]  ra2;

   // stimulus for dut_c
   logic        rst_c;
   logic        c_wr_en;
   logic [4:0]  c_wr_dest;
   logic [31:0] c_wr_data;
   logic [4:0]  c_ra1;
   logic [4:0]  c_zero_addr;
   logic        c_zero_bit;

   register_file_param_if #(.DATA_W(16), .ADDR_W(3)) if_a ();
   register_file_param_if #(.DATA_W(16), .ADDR_W(3)) if_b ();
   register_file_param_if #(.DATA_W(32), .ADDR_W(5)) if_c ();

   assign if_a.clear_req       = clr_req;
   assign if_a.reg_write_en    = wr_en;
   assign if_a.reg_write_dest  = wr_dest;
   assign if_a.reg_write_data  = wr_data;
   assign if_a.rsv_en          = rsv_en;
   assign if_a.rsv_addr        = rsv_addr;
   assign if_a.reg_read_addr_1 = ra1;
   assign if_a.reg_read_addr_2 = ra2;

   assign if_b.clear_req       = clr_req;
   assign if_b.reg_write_en    = wr_en;
   assign if_b.reg_write_dest  = wr_dest;
   assign if_b.reg_write_data  = wr_data;
   assign if_b.rsv_en          = rsv_en;
   assign if_b.rsv_addr        = rsv_addr;
   assign if_b.reg_read_addr_1 = ra1;
   assign if_b.reg_read_addr_2 = ra2;

   assign if_c.clear_req       = c_zero_bit;
   assign if_c.reg_write_en    = c_wr_en;
   assign if_c.reg_write_dest  = c_wr_dest;
   assign if_c.reg_write_data  = c_wr_data;
   assign if_c.rsv_en          = c_zero_bit;
   assign if_c.rsv_addr        = c_zero_addr;
   assign if_c.reg_read_addr_1 = c_ra1;
   assign if_c.reg_read_addr_2 = c_zero_addr;

   register_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_a (
      .clk (clk),
      .rst (rst_ab),
      .bus (if_a)
   );

   register_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
      .clk (clk),
      .rst (rst_ab),
      .bus (if_b)
   );

   register_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_c (
      .clk (clk),
      .rst (rst_c),
      .bus (if_c)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int          sb_dut [$];
   int          sb_fld [$];
   logic [31:0] sb_val [$];
   string       sb_name[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic exp_one(input int dut, input int fld, input logic [31:0] val, input string name);
      sb_dut.push_back(dut);
      sb_fld.push_back(fld);
      sb_val.push_back(val);
      sb_name.push_back(name);
   endtask

   task automatic exp_ab(input int fld, input logic [31:0] va, input logic [31:0] vb, input string name);
      exp_one(D_A, fld, va, {name, "_a"});
      exp_one(D_B, fld, vb, {name, "_b"});
   endtask

   function automatic logic [31:0] get_act(input int dut, input int fld);
      logic [31:0] v;
      v = 32'hXXXX_XXXX;
      case (dut)
         D_A: case (fld)
            F_BUSY: v = 32'(if_a.busy);
            F_RD1:  v = 32'(if_a.reg_read_data_1);
            F_RD2:  v = 32'(if_a.reg_read_data_2);
            F_P1:   v = 32'(if_a.pend_1);
            F_P2:   v = 32'(if_a.pend_2);
            default: v = 32'hXXXX_XXXX;
         endcase
         D_B: case (fld)
            F_BUSY: v = 32'(if_b.busy);
            F_RD1:  v = 32'(if_b.reg_read_data_1);
            F_RD2:  v = 32'(if_b.reg_read_data_2);
            F_P1:   v = 32'(if_b.pend_1);
            F_P2:   v = 32'(if_b.pend_2);
            default: v = 32'hXXXX_XXXX;
         endcase
         D_C: case (fld)
            F_BUSY: v = 32'(if_c.busy);
            F_RD1:  v = if_c.reg_read_data_1;
            F_RD2:  v = if_c.reg_read_data_2;
            F_P1:   v = 32'(if_c.pend_1);
            F_P2:   v = 32'(if_c.pend_2);
            default: v = 32'hXXXX_XXXX;
         endcase
         default: v = 32'hXXXX_XXXX;
      endcase
      return v;
   endfunction

   // Monitor: compares everything expected for the current cycle, away from
   // the rising edge.
   always @(negedge clk) begin
      while (sb_dut.size() > 0) begin
         int          d;
         int          f;
         logic [31:0] e;
         logic [31:0] act;
         string       nm;
         d   = sb_dut.pop_front();
         f   = sb_fld.pop_front();
         e   = sb_val.pop_front();
         nm  = sb_name.pop_front();
         act = get_act(d, f);
         n_tests++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, e, $time);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic idle();
      clr_req  = 1'b0;
      wr_en    = 1'b0;
      wr_dest  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
      c_wr_en  = 1'b0;
      c_wr_dest = '0;
      c_wr_data = '0;
   endtask

   // Ends the current cycle: rising edge, then inputs for the next cycle.
   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_write(input logic [2:0] dest, input logic [15:0] data);
      wr_en   = 1'b1;
      wr_dest = dest;
      wr_data = data;
   endtask

   task automatic do_rsv(input logic [2:0] addr);
      rsv_en   = 1'b1;
      rsv_addr = addr;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      c_zero_addr = '0;
      c_zero_bit  = 1'b0;
      c_ra1       = '0;
      ra1         = '0;
      ra2         = '0;
      rst_ab      = 1'b0;
      rst_c       = 1'b0;
      idle();

      // ---- 1: reset, clear runs 8 edges, writes dropped while busy --------
      step();                                   // first reset edge
      exp_ab(F_BUSY, 1, 1, "t1_busy_after_rst");
      step();                                   // second reset edge
      rst_ab = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i);
         if (i == 3) do_write(3'd3, 16'hBEEF);
         exp_ab(F_BUSY, 1, 1, "t1_busy");
         exp_ab(F_RD1,  0, 0, "t1_rd1_while_busy");
         exp_ab(F_P1,   0, 0, "t1_p1_while_busy");
         step();
      end
      ra1 = 3'd3;
      exp_ab(F_BUSY, 0, 0, "t1_busy_done");
      exp_ab(F_RD1,  0, 0, "t1_r3_write_dropped");
      exp_ab(F_P1,   0, 0, "t1_p1_idle");
      step();

      // ---- 2: write r5, read both ports ---------------------------------
      do_write(3'd5, 16'h1234);
      ra1 = 3'd5;
      ra2 = 3'd5;
      exp_ab(F_RD1, 32'h1234, 32'h0000, "t2_rd1_write_cycle");
      exp_ab(F_RD2, 32'h1234, 32'h0000, "t2_rd2_write_cycle");
      step();
      exp_ab(F_RD1, 32'h1234, 32'h1234, "t2_rd1_next");
      exp_ab(F_RD2, 32'h1234, 32'h1234, "t2_rd2_next");
      step();

      // ---- 3: zero register ----------------------------------------------
      do_write(3'd0, 16'hFFFF);
      do_rsv(3'd0);
      ra1 = 3'd0;
      exp_ab(F_RD1, 32'hFFFF, 32'h0, "t3_r0_write_cycle");
      exp_ab(F_P1,  0,        0,     "t3_r0_pend_write_cycle");
      step();
      exp_ab(F_RD1, 32'hFFFF, 32'h0, "t3_r0_next");
      exp_ab(F_P1,  1,        0,     "t3_r0_pend_next");
      step();
      do_write(3'd1, 16'hFFFF);
      ra2 = 3'd1;
      exp_ab(F_RD2, 32'hFFFF, 32'h0, "t3_r1_write_cycle");
      step();
      exp_ab(F_RD2, 32'hFFFF, 32'hFFFF, "t3_r1_next");
      step();

      // ---- 4: pending scoreboard -----------------------------------------
      ra1 = 3'd2;
      do_rsv(3'd2);
      exp_ab(F_P1, 0, 0, "t4_rsv_same_cycle");
      step();
      exp_ab(F_P1, 1, 1, "t4_rsv_next");
      step();
      do_write(3'd2, 16'hAAAA);
      exp_ab(F_P1,  0,        1,     "t4_pend_write_cycle");
      exp_ab(F_RD1, 32'hAAAA, 32'h0, "t4_rd_write_cycle");
      step();
      exp_ab(F_P1,  0,        0,        "t4_pend_after_write");
      exp_ab(F_RD1, 32'hAAAA, 32'hAAAA, "t4_rd_after_write");
      step();
      do_write(3'd2, 16'h5A5A);
      do_rsv(3'd2);
      exp_ab(F_P1,  0,        0,        "t4_rsv_wr_same_cycle_pend");
      exp_ab(F_RD1, 32'h5A5A, 32'hAAAA, "t4_rsv_wr_same_cycle_rd");
      step();
      exp_ab(F_P1,  1,        1,        "t4_rsv_wr_pend_after");
      exp_ab(F_RD1, 32'h5A5A, 32'h5A5A, "t4_rsv_wr_rd_after");
      step();

      // ---- 5: fill, verify, clear request --------------------------------
      for (int i = 0; i < 8; i++) begin
         do_write(3'(i), 16'(16'h0101 * i));
         step();
      end
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i);
         ra2 = 3'(7 - i);
         exp_ab(F_RD1, 32'(16'h0101 * i), (i == 0) ? 32'h0 : 32'(16'h0101 * i), "t5_fill_rd1");
         exp_ab(F_RD2, 32'(16'h0101 * (7 - i)), (i == 7) ? 32'h0 : 32'(16'h0101 * (7 - i)), "t5_fill_rd2");
         exp_ab(F_P1, 0, 0, "t5_fill_p1");
         exp_ab(F_P2, 0, 0, "t5_fill_p2");
         step();
      end
      do_rsv(3'd6);
      step();
      ra1 = 3'd6;
      exp_ab(F_P1, 1, 1, "t5_r6_pending");
      step();
      clr_req = 1'b1;
      do_write(3'd4, 16'hDEAD);
      ra1 = 3'd4;
      ra2 = 3'd6;
      exp_ab(F_BUSY, 0,        0,        "t5_clr_req_cycle_busy");
      exp_ab(F_RD1,  32'hDEAD, 32'h0404, "t5_clr_req_cycle_rd1");
      exp_ab(F_P2,   1,        1,        "t5_clr_req_cycle_p2");
      step();
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i);
         do_write(3'(i), 16'hFFFF);
         do_rsv(3'(i));
         clr_req = 1'b1;
         exp_ab(F_BUSY, 1, 1, "t5_clear_busy");
         exp_ab(F_RD1,  0, 0, "t5_clear_rd1");
         exp_ab(F_P1,   0, 0, "t5_clear_p1");
         step();
      end
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i);
         ra2 = 3'(i);
         exp_ab(F_BUSY, 0, 0, "t5_post_busy");
         exp_ab(F_RD1,  0, 0, "t5_post_rd1");
         exp_ab(F_RD2,  0, 0, "t5_post_rd2");
         exp_ab(F_P1,   0, 0, "t5_post_p1");
         exp_ab(F_P2,   0, 0, "t5_post_p2");
         step();
      end

      // ---- 6: reset during the 4th clear cycle ----------------------------
      do_write(3'd7, 16'h7777);
      step();
      clr_req = 1'b1;
      step();                                   // enters CLEAR
      for (int i = 0; i < 3; i++) begin
         exp_ab(F_BUSY, 1, 1, "t6_busy_before_rst");
         step();                                // clears entries 0..2
      end
      rst_ab = 1'b0;
      exp_ab(F_BUSY, 1, 1, "t6_busy_4th_cycle");
      step();                                   // reset edge restarts clear
      rst_ab = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_ab(F_BUSY, 1, 1, "t6_busy_restart");
         step();
      end
      ra1 = 3'd7;
      exp_ab(F_BUSY, 0, 0, "t6_busy_done");
      exp_ab(F_RD1,  0, 0, "t6_r7_cleared");
      step();

      // ---- 6b: wide instance, 32 clear edges -----------------------------
      rst_c = 1'b1;
      for (int i = 0; i < 32; i++) begin
         exp_one(D_C, F_BUSY, 1, "t6c_busy");
         step();
      end
      exp_one(D_C, F_BUSY, 0, "t6c_busy_done");
      c_wr_en   = 1'b1;
      c_wr_dest = 5'd31;
      c_wr_data = 32'hDEAD_BEEF;
      c_ra1     = 5'd31;
      exp_one(D_C, F_RD1, 32'hDEAD_BEEF, "t6c_bypass");
      step();
      exp_one(D_C, F_RD1, 32'hDEAD_BEEF, "t6c_stored");
      step();

      // let the monitor drain the last cycle
      @(negedge clk);
      #1;
      if (sb_dut.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_dut.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_register_file_param
